rsa_modexp5: RTL and testbench
==============================

# rsa_modexp5

Modular-exponentiation sequencer for the RSA datapath: computes `base^exp mod n` by left-to-right square-and-multiply. It sits directly upstream of the Blakley modular multiplier and drives that multiplier through a start/done handshake, issuing one squaring per exponent bit and one multiply per set bit. Results go to the top-level RSA controller.

## Interface
- `WIDTH`, 5: width of `base`, `n`, result and multiplier operands.
- `EXP_WIDTH`, 5: exponent width; every bit is processed, MSB first.

Ports:
- `clk`  in  1  the single clock; all state updates on the rising edge.
- `reset_l`  in  1  **synchronous, active-high reset** (asserted = 1, sampled on `clk`).
- `start`  in  1  request; sampled only in IDLE.
- `base`  in  WIDTH  message or ciphertext; any value, reduced internally.
- `exp`  in  EXP_WIDTH  exponent.
- `n`  in  WIDTH  modulus.
- `busy`  out  1  high from the cycle after `start` is accepted until `done`, inclusive.
- `done`  out  1  one-cycle pulse when `result` is valid.
- `result`  out  WIDTH  final value; holds until the next accepted `start`.
- `err`  out  1  set with `done` when `n == 0`; holds like `result`.
- `mul_start`  out  1  one-cycle pulse to the multiplier.
- `mul_a`, `mul_b`, `mul_n`  out  WIDTH each  multiplier operands; stable from the `mul_start` cycle through the `mul_done` cycle.
- `mul_done`  in  1  one-cycle pulse from the multiplier.
- `mul_result`  in  WIDTH  product mod `n`; valid when `mul_done` = 1.

## Operation
- States: IDLE, REDUCE, SQR_REQ, SQR_WAIT, MUL_REQ, MUL_WAIT, DONE.
- **IDLE:** on `start`, latch `base`, `exp` and `n`. Set acc = 1 and bit index i = EXP_WIDTH-1. Clear `err`.
  - `n == 0`: go to DONE with `result` = 0 and `err` = 1.
  - `n == 1`: go to DONE with `result` = 0 and `err` = 0.
  - Otherwise go to REDUCE.
- **REDUCE:** while base_r ≥ n, apply base_r ← base_r − n, one subtraction per cycle. When base_r < n, go to SQR_REQ in the following cycle.
- **SQR_REQ:** pulse `mul_start` with `mul_a` = `mul_b` = acc and `mul_n` = n. Go to SQR_WAIT.
- **SQR_WAIT:** on `mul_done`, set acc ← `mul_result`.
  - If exp_r[i] = 1, go to MUL_REQ.
  - Else if i == 0, go to DONE.
  - Else decrement i and go to SQR_REQ.
- **MUL_REQ:** pulse `mul_start` with `mul_a` = acc, `mul_b` = base_r and `mul_n` = n. Go to MUL_WAIT.
- **MUL_WAIT:** on `mul_done`, set acc ← `mul_result`.
  - If i == 0, go to DONE.
  - Else decrement i and go to SQR_REQ.
- **DONE:** drive `result` = acc and pulse `done` for one cycle. Return to IDLE.
- Operation count is EXP_WIDTH squarings plus popcount(exp) multiplies; leading exponent zeros are not skipped.
- `exp == 0` with n > 1 yields 1.
- The bit index counter is $clog2(EXP_WIDTH) bits wide and never underflows, because i == 0 is checked before decrementing.
- **Ignored inputs:**
  - `start` outside IDLE is ignored.
  - `mul_done` outside SQR_WAIT/MUL_WAIT is ignored.
  - `mul_result` is never checked against `n`.
- **Reset:** all outputs go to 0 and state goes to IDLE. This applies mid-operation as well; `mul_start` drops that same edge. A late `mul_done` arriving after reset is ignored.

## Timing
- `start` is sampled at cycle T. `busy` = 1 from T+1 through the `done` cycle.
- Trivial moduli (`n` = 0 or 1): `done` at T+1.
- REDUCE occupies T+1 .. T+1+k, where k = floor(base/n). The first `mul_start` is at T+2+k.
- Multiplier latency L ≥ 1: `mul_done` arrives L cycles after `mul_start`. The next `mul_start` follows one cycle after that `mul_done`, so each operation costs L+1 cycles.
- `done` at T+2+k+(EXP_WIDTH+popcount(exp))·(L+1).
- A new `start` is accepted in the cycle after `done`.
- `mul_start` is never high in two consecutive cycles.
- `mul_start` is never asserted while a multiplier operation is outstanding.

## Test plan
Bench uses a behavioural multiplier model with L = 3 unless stated otherwise.
- **Basic:** base=4, exp=13, n=17 at T → exactly 8 `mul_start` pulses, `done` at T+34, `result`=4, `err`=0.
- **Reduction:** base=23, exp=5, n=7 → REDUCE takes k=3 subtraction cycles, 7 operations, `result`=4, `done` at T+33.
- **Zero exponent:** base=9, exp=0, n=13 → 5 squarings and no multiplies, `result`=1.
- **Trivial moduli:** n=1 → `done` at T+1, `result`=0, `err`=0, no `mul_start`. n=0 → `done` at T+1, `result`=0, `err`=1.
- **Protocol:** `start` pulsed mid-operation is ignored and `result` is unchanged. Repeat the basic case with L=1 and L=7 → same `result`, with `done` at T+18 and T+66 respectively.
- **Reset:** `reset_l`=1 for one cycle while in SQR_WAIT → next cycle IDLE with `busy`/`done`/`mul_start`=0. The model's late `mul_done` is ignored. A fresh `start` then completes correctly.

Source files
------------

// File: rtl/rsa_modexp5.sv
// rtl/rsa_modexp5.sv - left-to-right square-and-multiply modular exponentiation sequencer
//
// Computes base^exp mod n by driving an external modular multiplier through a
// one-cycle start / one-cycle done handshake: one squaring per exponent bit
// (MSB first, leading zeros included) and one multiply per set bit.
//
// Ports:
//   clk         in   rising-edge clock
//   reset_l     in   synchronous reset, active high
//   start       in   request, sampled only while idle
//   base        in   WIDTH      message / ciphertext, reduced mod n internally
//   exp         in   EXP_WIDTH  exponent
//   n           in   WIDTH      modulus
//   busy        out  high from the cycle after an accepted start through done
//   done        out  one-cycle pulse, result/err valid
//   result      out  WIDTH      final value, held until the next accepted start
//   err         out  set with done when n == 0, held like result
//   mul_start   out  one-cycle request to the multiplier
//   mul_a       out  WIDTH      multiplier operand a
//   mul_b       out  WIDTH      multiplier operand b
//   mul_n       out  WIDTH      multiplier modulus
//   mul_done    in   one-cycle completion pulse from the multiplier
//   mul_result  in   WIDTH      product mod n, valid with mul_done

module rsa_modexp5 #(
    parameter int WIDTH     = 5,
    parameter int EXP_WIDTH = 5
) (
    input  logic                 clk,
    input  logic                 reset_l,
    input  logic                 start,
    input  logic [WIDTH-1:0]     base,
    input  logic [EXP_WIDTH-1:0] exp,
    input  logic [WIDTH-1:0]     n,
    output logic                 busy,
    output logic                 done,
    output logic [WIDTH-1:0]     result,
    output logic                 err,
    output logic                 mul_start,
    output logic [WIDTH-1:0]     mul_a,
    output logic [WIDTH-1:0]     mul_b,
    output logic [WIDTH-1:0]     mul_n,
    input  logic                 mul_done,
    input  logic [WIDTH-1:0]     mul_result
);

    // A 1-bit exponent still needs a 1-bit index register.
    localparam int               IDX_W   = (EXP_WIDTH > 1) ? $clog2(EXP_WIDTH) : 1;
    localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(EXP_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REDUCE,
        S_SQR_REQ,
        S_SQR_WAIT,
        S_MUL_REQ,
        S_MUL_WAIT,
        S_DONE
    } state_t;

    state_t                 r_state;
    logic [WIDTH-1:0]       r_base;
    logic [EXP_WIDTH-1:0]   r_exp;
    logic [WIDTH-1:0]       r_n;
    logic [WIDTH-1:0]       r_acc;
    logic [IDX_W-1:0]       r_idx;
    logic [WIDTH-1:0]       r_result;
    logic                   r_err;

    state_t                 w_state_next;
    logic [WIDTH-1:0]       w_base_next;
    logic [EXP_WIDTH-1:0]   w_exp_next;
    logic [WIDTH-1:0]       w_n_next;
    logic [WIDTH-1:0]       w_acc_next;
    logic [IDX_W-1:0]       w_idx_next;
    logic [WIDTH-1:0]       w_result_next;
    logic                   w_err_next;
    logic                   w_idx_zero;
    logic                   w_exp_bit;
    logic                   w_mul_phase;

    assign w_idx_zero  = (r_idx == '0);
    assign w_exp_bit   = r_exp[r_idx];
    assign w_mul_phase = (r_state == S_MUL_REQ) || (r_state == S_MUL_WAIT);

    // State register. Reset clears every register that feeds an output, so all
    // outputs (including the operand buses) read zero from the reset edge on.
    always_ff @(posedge clk) begin
        if (reset_l) begin
            r_state  <= S_IDLE;
            r_base   <= '0;
            r_exp    <= '0;
            r_n      <= '0;
            r_acc    <= '0;
            r_idx    <= '0;
            r_result <= '0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_base   <= w_base_next;
            r_exp    <= w_exp_next;
            r_n      <= w_n_next;
            r_acc    <= w_acc_next;
            r_idx    <= w_idx_next;
            r_result <= w_result_next;
            r_err    <= w_err_next;
        end
    end

    // Next-state and datapath updates.
    always_comb begin
        w_state_next  = r_state;
        w_base_next   = r_base;
        w_exp_next    = r_exp;
        w_n_next      = r_n;
        w_acc_next    = r_acc;
        w_idx_next    = r_idx;
        w_result_next = r_result;
        w_err_next    = r_err;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_base_next   = base;
                    w_exp_next    = exp;
                    w_n_next      = n;
                    w_acc_next    = WIDTH'(1);
                    w_idx_next    = IDX_MSB;
                    w_result_next = '0;
                    w_err_next    = 1'b0;
                    // Trivial moduli finish immediately with result 0; only
                    // n == 0 is flagged as an error.
                    if (n == '0) begin
                        w_err_next   = 1'b1;
                        w_state_next = S_DONE;
                    end else if (n == WIDTH'(1)) begin
                        w_state_next = S_DONE;
                    end else begin
                        w_state_next = S_REDUCE;
                    end
                end
            end

            // Repeated subtraction instead of a divider: the multiplier
            // expects operands already below n.
            S_REDUCE: begin
                if (r_base >= r_n) begin
                    w_base_next = r_base - r_n;
                end else begin
                    w_state_next = S_SQR_REQ;
                end
            end

            S_SQR_REQ: begin
                w_state_next = S_SQR_WAIT;
            end

            S_SQR_WAIT: begin
                if (mul_done) begin
                    w_acc_next = mul_result;
                    if (w_exp_bit) begin
                        w_state_next = S_MUL_REQ;
                    end else if (w_idx_zero) begin
                        // Result is captured on the way into DONE so it is
                        // already valid in the cycle done pulses.
                        w_result_next = mul_result;
                        w_state_next  = S_DONE;
                    end else begin
                        w_idx_next   = r_idx - 1'b1;
                        w_state_next = S_SQR_REQ;
                    end
                end
            end

            S_MUL_REQ: begin
                w_state_next = S_MUL_WAIT;
            end

            S_MUL_WAIT: begin
                if (mul_done) begin
                    w_acc_next = mul_result;
                    if (w_idx_zero) begin
                        w_result_next = mul_result;
                        w_state_next  = S_DONE;
                    end else begin
                        w_idx_next   = r_idx - 1'b1;
                        w_state_next = S_SQR_REQ;
                    end
                end
            end

            S_DONE: begin
                w_state_next = S_IDLE;
            end

            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Outputs decode directly from registers. Operands come from r_acc /
    // r_base / r_n, which only change on the mul_done edge, so they stay
    // stable from mul_start through mul_done without extra holding registers.
    assign busy      = (r_state != S_IDLE);
    assign done      = (r_state == S_DONE);
    assign result    = r_result;
    assign err       = r_err;
    assign mul_start = (r_state == S_SQR_REQ) || (r_state == S_MUL_REQ);
    assign mul_a     = r_acc;
    assign mul_b     = w_mul_phase ? r_base : r_acc;
    assign mul_n     = r_n;

endmodule

// File: tb/tb_rsa_modexp5.sv
// tb/tb_rsa_modexp5.sv - directed self-checking bench for rsa_modexp5

module tb_rsa_modexp5;

    logic       clk     = 1'b0;
    logic       reset_l = 1'b1;
    logic       start   = 1'b0;
    logic [4:0] base_i  = 5'd0;
    logic [4:0] exp_i   = 5'd0;
    logic [4:0] n_i     = 5'd0;
    logic       busy;
    logic       done;
    logic [4:0] result;
    logic       err;
    logic       mul_start;
    logic [4:0] mul_a;
    logic [4:0] mul_b;
    logic [4:0] mul_n;
    logic       mul_done   = 1'b0;
    logic [4:0] mul_result = 5'd0;

    int errors = 0;
    int checks = 0;

    rsa_modexp5 #(.WIDTH(5), .EXP_WIDTH(5)) dut (
        .clk        (clk),
        .reset_l    (reset_l),
        .start      (start),
        .base       (base_i),
        .exp        (exp_i),
        .n          (n_i),
        .busy       (busy),
        .done       (done),
        .result     (result),
        .err        (err),
        .mul_start  (mul_start),
        .mul_a      (mul_a),
        .mul_b      (mul_b),
        .mul_n      (mul_n),
        .mul_done   (mul_done),
        .mul_result (mul_result)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural multiplier with programmable latency plus protocol monitor.
    // It deliberately ignores reset so a late mul_done can follow an abort.
    int         mul_lat       = 3;
    int         m_cnt         = 0;
    logic [4:0] m_res         = 5'd0;
    logic [4:0] cap_a         = 5'd0;
    logic [4:0] cap_b         = 5'd0;
    logic [4:0] cap_n         = 5'd0;
    logic       prev_ms       = 1'b0;
    int         mul_start_cnt = 0;
    int         done_cnt      = 0;
    int         prot_viol     = 0;
    int         v_tmp;

    function automatic logic [4:0] modmul(input logic [4:0] a, input logic [4:0] b, input logic [4:0] m);
        if (m == 5'd0) return 5'd0;
        return 5'((int'(a) * int'(b)) % int'(m));
    endfunction

    always @(posedge clk) begin
        v_tmp = 0;
        mul_done <= 1'b0;
        prev_ms  <= mul_start;
        if (mul_start) mul_start_cnt <= mul_start_cnt + 1;
        if (done) done_cnt <= done_cnt + 1;
        if (mul_start && prev_ms) v_tmp++;
        if (mul_start && (m_cnt != 0 || mul_done)) v_tmp++;
        if (mul_done && busy && (mul_a !== cap_a || mul_b !== cap_b || mul_n !== cap_n)) v_tmp++;
        if (v_tmp != 0) prot_viol <= prot_viol + v_tmp;
        if (m_cnt != 0) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1) begin
                mul_done   <= 1'b1;
                mul_result <= m_res;
            end
        end
        if (mul_start) begin
            cap_a <= mul_a;
            cap_b <= mul_b;
            cap_n <= mul_n;
            m_res <= modmul(mul_a, mul_b, mul_n);
            if (mul_lat <= 1) begin
                mul_done   <= 1'b1;
                mul_result <= modmul(mul_a, mul_b, mul_n);
            end else begin
                m_cnt <= mul_lat - 1;
            end
        end
    end

    // Issues one request and waits for done; latency is -1 on timeout.
    task automatic run_op(input logic [4:0] b, input logic [4:0] e, input logic [4:0] nn, input int lat,
                          output int latency, output logic [4:0] res, output logic er,
                          output int nst, output int gaps);
        int t0;
        int s0;
        @(negedge clk);
        mul_lat = lat;
        base_i  = b;
        exp_i   = e;
        n_i     = nn;
        start   = 1'b1;
        t0      = cyc;
        s0      = mul_start_cnt;
        gaps    = 0;
        latency = -1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 300; k++) begin
            if (done === 1'b1) begin
                latency = cyc - t0;
                break;
            end
            if (busy !== 1'b1) gaps++;
            @(negedge clk);
        end
        res = result;
        er  = err;
        nst = mul_start_cnt - s0;
    endtask

    task automatic test_reset;
        reset_l = 1'b1;
        start   = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, err, mul_start} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ctrl: busy/done/err/mul_start=%b required 0000", {busy, done, err, mul_start});
        end
        checks++;
        if ({result, mul_a, mul_b, mul_n} !== 20'd0) begin
            errors++;
            $display("FAIL reset_data: result=%0d mul_a=%0d mul_b=%0d mul_n=%0d required all 0", result, mul_a, mul_b, mul_n);
        end
        reset_l = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic;
        int lat; logic [4:0] res; logic er; int nst; int gaps;
        run_op(5'd4, 5'd13, 5'd17, 3, lat, res, er, nst, gaps);
        checks++;
        if (lat !== 34) begin errors++; $display("FAIL basic_latency: got %0d required 34", lat); end
        checks++;
        if (res !== 5'd4 || er !== 1'b0) begin errors++; $display("FAIL basic_result: result=%0d err=%b required 4/0", res, er); end
        checks++;
        if (nst !== 8) begin errors++; $display("FAIL basic_mul_starts: got %0d required 8", nst); end
        checks++;
        if (gaps !== 0 || busy !== 1'b1) begin errors++; $display("FAIL basic_busy: gaps=%0d busy_at_done=%b required 0/1", gaps, busy); end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || result !== 5'd4) begin
            errors++;
            $display("FAIL basic_after_done: done=%b busy=%b result=%0d required 0/0/4", done, busy, result);
        end
    endtask

    task automatic test_reduction;
        int lat; logic [4:0] res; logic er; int nst; int gaps;
        run_op(5'd23, 5'd5, 5'd7, 3, lat, res, er, nst, gaps);
        checks++;
        if (lat !== 33 || res !== 5'd4 || nst !== 7) begin
            errors++;
            $display("FAIL reduction: latency=%0d result=%0d mul_starts=%0d required 33/4/7", lat, res, nst);
        end
    endtask

    task automatic test_zero_exp;
        int lat; logic [4:0] res; logic er; int nst; int gaps;
        run_op(5'd9, 5'd0, 5'd13, 3, lat, res, er, nst, gaps);
        checks++;
        if (lat !== 22 || res !== 5'd1 || nst !== 5 || er !== 1'b0) begin
            errors++;
            $display("FAIL zero_exp: latency=%0d result=%0d mul_starts=%0d err=%b required 22/1/5/0", lat, res, nst, er);
        end
    endtask

    task automatic test_full_exp;
        int lat; logic [4:0] res; logic er; int nst; int gaps;
        run_op(5'd3, 5'd31, 5'd31, 3, lat, res, er, nst, gaps);
        checks++;
        if (lat !== 42 || res !== 5'd3 || nst !== 10) begin
            errors++;
            $display("FAIL full_exp: latency=%0d result=%0d mul_starts=%0d required 42/3/10", lat, res, nst);
        end
    endtask

    task automatic test_trivial;
        int lat; logic [4:0] res; logic er; int nst; int gaps;
        run_op(5'd7, 5'd3, 5'd0, 3, lat, res, er, nst, gaps);
        checks++;
        if (lat !== 1 || res !== 5'd0 || er !== 1'b1 || nst !== 0) begin
            errors++;
            $display("FAIL trivial_n0: latency=%0d result=%0d err=%b mul_starts=%0d required 1/0/1/0", lat, res, er, nst);
        end
        @(negedge clk);
        checks++;
        if (err !== 1'b1) begin errors++; $display("FAIL trivial_err_hold: err=%b required 1", err); end
        run_op(5'd7, 5'd3, 5'd1, 3, lat, res, er, nst, gaps);
        checks++;
        if (lat !== 1 || res !== 5'd0 || er !== 1'b0 || nst !== 0) begin
            errors++;
            $display("FAIL trivial_n1: latency=%0d result=%0d err=%b mul_starts=%0d required 1/0/0/0", lat, res, er, nst);
        end
    endtask

    task automatic test_latency;
        int lat; logic [4:0] res; logic er; int nst; int gaps;
        run_op(5'd4, 5'd13, 5'd17, 1, lat, res, er, nst, gaps);
        checks++;
        if (lat !== 18 || res !== 5'd4) begin errors++; $display("FAIL lat1: latency=%0d result=%0d required 18/4", lat, res); end
        run_op(5'd4, 5'd13, 5'd17, 7, lat, res, er, nst, gaps);
        checks++;
        if (lat !== 66 || res !== 5'd4) begin errors++; $display("FAIL lat7: latency=%0d result=%0d required 66/4", lat, res); end
    endtask

    task automatic test_start_ignored;
        int t0; int lat;
        @(negedge clk);
        mul_lat = 3; base_i = 5'd4; exp_i = 5'd13; n_i = 5'd17; start = 1'b1;
        t0 = cyc;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        start = 1'b1; base_i = 5'd3; exp_i = 5'd1; n_i = 5'd5;
        @(negedge clk);
        start = 1'b0;
        lat = -1;
        for (int k = 0; k < 300; k++) begin
            if (done === 1'b1) begin lat = cyc - t0; break; end
            @(negedge clk);
        end
        checks++;
        if (lat !== 34 || result !== 5'd4) begin
            errors++;
            $display("FAIL start_ignored: latency=%0d result=%0d required 34/4", lat, result);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL start_ignored_idle: busy=%b required 0", busy); end
    endtask

    task automatic test_back_to_back;
        int lat; logic [4:0] res; logic er; int nst; int gaps;
        run_op(5'd4, 5'd13, 5'd17, 3, lat, res, er, nst, gaps);
        checks++;
        if (lat !== 34 || res !== 5'd4) begin errors++; $display("FAIL b2b_first: latency=%0d result=%0d required 34/4", lat, res); end
        run_op(5'd23, 5'd5, 5'd7, 3, lat, res, er, nst, gaps);
        checks++;
        if (lat !== 33 || res !== 5'd4) begin errors++; $display("FAIL b2b_second: latency=%0d result=%0d required 33/4", lat, res); end
    endtask

    task automatic test_reset_mid;
        int d0; int s0; int lat; logic [4:0] res; logic er; int nst; int gaps;
        @(negedge clk);
        mul_lat = 3; base_i = 5'd4; exp_i = 5'd13; n_i = 5'd17; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        checks++;
        if (mul_start !== 1'b1 || mul_a !== 5'd1 || mul_b !== 5'd1 || mul_n !== 5'd17) begin
            errors++;
            $display("FAIL first_mul_start: mul_start=%b a=%0d b=%0d n=%0d required 1/1/1/17", mul_start, mul_a, mul_b, mul_n);
        end
        @(negedge clk);
        reset_l = 1'b1;
        d0 = done_cnt;
        @(negedge clk);
        checks++;
        if ({busy, done, mul_start, err} !== 4'b0000 || result !== 5'd0) begin
            errors++;
            $display("FAIL reset_mid: busy/done/mul_start/err=%b result=%0d required 0000/0", {busy, done, mul_start, err}, result);
        end
        reset_l = 1'b0;
        s0 = mul_start_cnt;
        repeat (6) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done_cnt !== d0 || mul_start_cnt !== s0) begin
            errors++;
            $display("FAIL late_mul_done: busy=%b dones=%0d mul_starts=%0d required 0/%0d/%0d", busy, done_cnt, mul_start_cnt, d0, s0);
        end
        run_op(5'd4, 5'd13, 5'd17, 3, lat, res, er, nst, gaps);
        checks++;
        if (lat !== 34 || res !== 5'd4 || nst !== 8) begin
            errors++;
            $display("FAIL after_reset: latency=%0d result=%0d mul_starts=%0d required 34/4/8", lat, res, nst);
        end
    endtask

    task automatic test_protocol;
        checks++;
        if (prot_viol !== 0) begin
            errors++;
            $display("FAIL mul_protocol: violations=%0d required 0", prot_viol);
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_reduction;
        test_zero_exp;
        test_full_exp;
        test_trivial;
        test_latency;
        test_start_ignored;
        test_back_to_back;
        test_reset_mid;
        test_protocol;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
